serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/bit_add_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/bit_add_cell.sv
// One-bit full adder cell used by the serial adder datapath.
module bit_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one operand bit per RUN cycle, LSB first, result in WIDTH cycles.
// Defining SERIAL_ADD_OVERFLOW_EN adds a registered signed-overflow output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, sum_q;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic             s_bit, c_bit;
    logic             accept, last;

    assign accept = start && (state_q != RUN);
    assign last   = (count_q == CW'(WIDTH - 1));

    bit_add_cell u_cell (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (s_bit),
        .cout (c_bit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opa_q   <= a;
                opb_q   <= b;
                sum_q   <= '0;
                count_q <= '0;
                carry_q <= carryin;
            end else if (state_q == RUN) begin
                // Sum fills from the MSB so the first-computed LSB lands at bit 0 after WIDTH shifts.
                sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
                opa_q   <= opa_q >> 1;
                opb_q   <= opb_q >> 1;
                carry_q <= c_bit;
                count_q <= count_q + CW'(1);
            end
        end
    end

`ifdef SERIAL_ADD_OVERFLOW_EN
    logic ovf_q;

    // On the last cycle carry_q is the carry into the MSB and c_bit the carry out.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last) begin
            ovf_q <= carry_q ^ c_bit;
        end
    end

    assign overflow = ovf_q;
`endif

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign carryout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed corner cases plus random additions.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             carryin;
    logic             busy, done, carryout;
    logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             overflow;
`endif

    typedef struct {
        logic [WIDTH:0] res;
        logic           ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout)
`ifdef SERIAL_ADD_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    // Reference: unsigned sum for {carryout,sum}, signed range test for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
        exp_t e;
        int   half, sx, sy, st;
        e.res = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        half  = 1 << (WIDTH - 1);
        sx    = (int'(x) >= half) ? int'(x) - 2 * half : int'(x);
        sy    = (int'(y) >= half) ? int'(y) - 2 * half : int'(y);
        st    = sx + sy + int'(c);
        e.ovf = (st >= half) || (st < -half);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.res[WIDTH-1:0]));
                check("carryout", 32'(carryout), 32'(e.res[WIDTH]));
`ifdef SERIAL_ADD_OVERFLOW_EN
                check("overflow", 32'(overflow), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                         input bit hold);
        @(posedge clk);
        #1;
        start   = 1'b1;
        a       = x;
        b       = y;
        carryin = c;
        sb.push_back(model(x, y, c));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int n   = 0;
        bit got = 0;
        for (int i = 0; i < 4 * WIDTH + 8; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            if (busy) n++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end else begin
            check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        end
    endtask

    initial begin
        logic [31:0] r;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        carryin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_carryout", 32'(carryout), 32'd0);
`ifdef SERIAL_ADD_OVERFLOW_EN
        check("reset_overflow", 32'(overflow), 32'd0);
`endif
        reset = 1'b0;

        issue(8'h0F, 8'h01, 1'b0, 0);
        wait_done("add_0f_01", WIDTH);
        issue(8'hFF, 8'h01, 1'b0, 0);
        wait_done("add_ff_01", WIDTH);
        issue(8'h7F, 8'h01, 1'b0, 0);
        wait_done("add_7f_01", WIDTH);
        issue(8'h00, 8'h00, 1'b1, 0);
        wait_done("add_cin_only", WIDTH);

        // Start pulsed during RUN must be ignored.
        issue(8'h12, 8'h34, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_start", WIDTH - 3);

        // Reset mid-RUN aborts with no done pulse.
        issue(8'h55, 8'h66, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_carryout", 32'(carryout), 32'd0);
        repeat (WIDTH + 4) @(posedge clk);
        issue(8'h01, 8'h01, 1'b0, 0);
        wait_done("after_abort", WIDTH);

        // Back-to-back: start held through DONE.
        issue(8'h01, 8'h02, 1'b0, 1);
        a       = 8'h80;
        b       = 8'h80;
        carryin = 1'b0;
        sb.push_back(model(8'h80, 8'h80, 1'b0));
        wait_done("b2b_first", WIDTH);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_second", WIDTH);

        for (int k = 0; k < 20; k++) begin
            logic [WIDTH-1:0] x, y;
            r = $urandom;
            x = r[WIDTH-1:0];
            r = $urandom;
            y = r[WIDTH-1:0];
            r = $urandom;
            issue(x, y, r[0], 0);
            wait_done("random", WIDTH);
            repeat (r[2:1]) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
